// File: rtl/cpu_instr_loader.sv
// cpu_instr_loader: CPU-side instruction loader for the compute core.
// The CPU writes 32-bit halves into a 64-bit instruction memory, then writes
// the all-ones CTRL address to start. The block streams instructions to the
// core until an END opcode (or the last usable slot), waits for the core to
// drain, and raises a level irq that any later CTRL write clears.
//
// Core handshake: core_instr_valid/data/pc are registered and held stable
// while valid=1 and ready=0; a transfer happens on a rising edge where both
// valid and ready are 1, and valid drops on that same edge.
module cpu_instr_loader #(
  parameter int INSTR_NUM_BIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     CPU_instruction_valid,
  input  logic [INSTR_NUM_BIT:0]   CPU_instruction_addr,
  input  logic [31:0]              CPU_instruction_data,
  output logic                     CPU_instruction_irq,
  output logic                     core_instr_valid,
  input  logic                     core_instr_ready,
  output logic [63:0]              core_instr_data,
  output logic [INSTR_NUM_BIT-1:0] core_instr_pc,
  input  logic                     core_busy,
  output logic [2:0]               dbg_state
);

  localparam int DEPTH = 1 << INSTR_NUM_BIT;

  // All-ones bus address is CTRL; its instruction index is the reserved slot.
  localparam logic [INSTR_NUM_BIT:0]   CTRL_ADDR = '1;
  localparam logic [INSTR_NUM_BIT-1:0] RSVD_SLOT = '1;
  localparam logic [INSTR_NUM_BIT-1:0] LAST_PC   = {{(INSTR_NUM_BIT-1){1'b1}}, 1'b0};
  localparam logic [7:0]               END_OPC   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                   state;
  logic [INSTR_NUM_BIT-1:0] pc;
  logic [63:0]              rd_data;

  // Halves are stored separately so a 32-bit write touches only its half.
  logic [31:0] mem_lo [DEPTH];
  logic [31:0] mem_hi [DEPTH];

  logic                     cpu_accept;
  logic                     is_ctrl;
  logic [INSTR_NUM_BIT-1:0] wr_idx;
  logic                     mem_we;
  logic                     ctrl_we;

  // CPU writes only land while the block is not running a program.
  assign cpu_accept = CPU_instruction_valid && ((state == S_IDLE) || (state == S_DONE));
  assign is_ctrl    = (CPU_instruction_addr == CTRL_ADDR);
  assign wr_idx     = CPU_instruction_addr[INSTR_NUM_BIT:1];
  assign mem_we     = cpu_accept && !is_ctrl && (wr_idx != RSVD_SLOT);
  assign ctrl_we    = cpu_accept && is_ctrl;

  assign dbg_state  = state;

  // Instruction memory: half-word writes, one-cycle synchronous read in FETCH.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (CPU_instruction_addr[0]) begin
        mem_hi[wr_idx] <= CPU_instruction_data;
      end else begin
        mem_lo[wr_idx] <= CPU_instruction_data;
      end
    end
    if (state == S_FETCH) begin
      rd_data <= {mem_hi[pc], mem_lo[pc]};
    end
  end

  // Sequencer: fetch, check for END, offer to core, drain, then interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      pc                  <= '0;
      core_instr_valid    <= 1'b0;
      core_instr_data     <= '0;
      core_instr_pc       <= '0;
      CPU_instruction_irq <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl_we && CPU_instruction_data[0]) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (rd_data[63:56] == END_OPC) begin
            state <= S_DRAIN;
          end else begin
            core_instr_valid <= 1'b1;
            core_instr_data  <= rd_data;
            core_instr_pc    <= pc;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (core_instr_ready) begin
            core_instr_valid <= 1'b0;
            if (pc == LAST_PC) begin
              state <= S_DRAIN;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          if (!core_busy) begin
            CPU_instruction_irq <= 1'b1;
            state               <= S_DONE;
          end
        end
        S_DONE: begin
          if (ctrl_we) begin
            CPU_instruction_irq <= 1'b0;
            pc                  <= '0;
            state               <= CPU_instruction_data[0] ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_instr_loader.sv
// Directed bench for cpu_instr_loader: loads small programs over the CPU bus,
// runs them against a scripted core, and scores every offer against a queue.
module tb_cpu_instr_loader;

  localparam int N = 8;
  localparam logic [8:0] CTRL = 9'h1ff;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [63:0] END_W   = 64'hFF00_0000_0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_valid = 1'b0;
  logic [8:0]  cpu_addr  = '0;
  logic [31:0] cpu_data  = '0;
  logic        irq;
  logic        valid;
  logic        ready = 1'b0;
  logic [63:0] data;
  logic [7:0]  pc;
  logic        busy = 1'b0;
  logic [2:0]  st;

  cpu_instr_loader #(.INSTR_NUM_BIT(N)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .CPU_instruction_valid (cpu_valid),
    .CPU_instruction_addr  (cpu_addr),
    .CPU_instruction_data  (cpu_data),
    .CPU_instruction_irq   (irq),
    .core_instr_valid      (valid),
    .core_instr_ready      (ready),
    .core_instr_data       (data),
    .core_instr_pc         (pc),
    .core_busy             (busy),
    .dbg_state             (st)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cnt = 0;
  int hs_cyc = 0;
  int ready_mode = 1;  // 0 low, 1 high, 2 toggle, 3 stall on pc 1

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [7:0]  exp_pc_q[$];

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [63:0] pd = '0;
  logic [7:0]  ppc = '0;

  // Offers are sampled on the falling edge, half a cycle before the transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", valid, 1'b1);
          check("hold_data", data, pd);
          check("hold_pc", pc, ppc);
        end
        if (valid && ready) begin
          check("offer_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            check("offer_data", data, exp_q.pop_front());
            check("offer_pc", pc, exp_pc_q.pop_front());
          end
          hs_cnt++;
          hs_cyc = cyc;
        end
        pv  = valid;
        pr  = ready;
        pd  = data;
        ppc = pc;
      end
    end
  end

  // Core ready driver, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        2:       ready = ~ready;
        default: ready = (pc != 8'd1);
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_data  = d;
    tick(1);
    cpu_valid = 1'b0;
  endtask

  task automatic load(input int idx, input logic [63:0] w);
    logic [7:0] i8;
    i8 = idx[7:0];
    cpu_write({i8, 1'b0}, w[31:0]);
    cpu_write({i8, 1'b1}, w[63:32]);
  endtask

  task automatic wait_hs(input int n, input int max_cyc);
    int k;
    k = 0;
    while (hs_cnt < n && k < max_cyc) begin
      tick(1);
      k++;
    end
    check("hs_count", hs_cnt, n);
  endtask

  task automatic wait_irq(input int max_cyc, output int c);
    int k;
    k = 0;
    while (!irq && k < max_cyc) begin
      tick(1);
      k++;
    end
    check("irq_rise", irq, 1'b1);
    c = cyc;
  endtask

  logic [63:0] prog_a0 = 64'h1111_1111_0000_0000;
  logic [63:0] prog_a1 = 64'h2222_2222_0000_0001;

  task automatic push_prog_a();
    exp_q.push_back(prog_a0);
    exp_pc_q.push_back(8'd0);
    exp_q.push_back(prog_a1);
    exp_pc_q.push_back(8'd1);
  endtask

  function automatic logic [63:0] mk(input int i);
    return {8'h01, 8'(i), 16'hBEEF, 32'(i * 7 + 3)};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    int k;

    tick(2);
    check("rst_irq", irq, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_data", data, 64'h0);
    check("rst_pc", pc, 8'h0);
    check("rst_state", st, ST_IDLE);
    rst = 1'b0;
    tick(1);

    // Basic run, ready high, core idle.
    load(0, prog_a0);
    load(1, prog_a1);
    load(2, END_W);
    ready_mode = 1;
    hs_cnt = 0;
    push_prog_a();
    cpu_write(CTRL, 32'h1);
    check("start_fetch", st, ST_FETCH);
    tick(1);
    check("check_no_valid", valid, 1'b0);
    tick(1);
    check("first_valid", valid, 1'b1);
    check("first_pc", pc, 8'd0);
    wait_hs(2, 50);
    wait_irq(20, c);
    check("irq_latency", c - hs_cyc, 4);
    check("done_state", st, ST_DONE);
    check("queue_empty", exp_q.size(), 0);

    // Memory write in DONE, then restart with stalls and a busy core.
    cpu_write(9'h000, 32'h0000_00AA);
    prog_a0 = 64'h1111_1111_0000_00AA;
    check("irq_kept_on_memwr", irq, 1'b1);
    busy = 1'b1;
    ready_mode = 2;
    hs_cnt = 0;
    push_prog_a();
    cpu_write(CTRL, 32'h1);
    check("restart_irq_clr", irq, 1'b0);
    check("restart_fetch", st, ST_FETCH);
    tick(2);
    check("restart_valid", valid, 1'b1);
    check("restart_pc", pc, 8'd0);
    wait_hs(2, 100);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("irq_held_by_busy", irq, 1'b0);
    end
    busy = 1'b0;
    wait_irq(10, c);
    check("queue_empty2", exp_q.size(), 0);

    // CTRL=0 in DONE returns to idle.
    cpu_write(CTRL, 32'h0);
    check("stop_irq_clr", irq, 1'b0);
    check("stop_idle", st, ST_IDLE);
    tick(3);
    check("stay_idle", st, ST_IDLE);
    check("idle_no_valid", valid, 1'b0);

    // Writes while running are ignored.
    ready_mode = 0;
    hs_cnt = 0;
    push_prog_a();
    cpu_write(CTRL, 32'h1);
    tick(2);
    check("stall_valid", valid, 1'b1);
    cpu_write(9'h003, 32'hDEAD_BEEF);
    cpu_write(CTRL, 32'h1);
    check("busy_state", st, ST_ISSUE);
    check("busy_pc", pc, 8'd0);
    check("busy_data", data, prog_a0);
    ready_mode = 1;
    wait_hs(2, 50);
    wait_irq(20, c);
    check("queue_empty3", exp_q.size(), 0);

    // Reset during ISSUE of pc 1, then replay.
    ready_mode = 3;
    hs_cnt = 0;
    exp_q.push_back(prog_a0);
    exp_pc_q.push_back(8'd0);
    cpu_write(CTRL, 32'h1);
    k = 0;
    while (!(valid && pc == 8'd1) && k < 30) begin
      tick(1);
      k++;
    end
    check("reach_pc1", valid && pc == 8'd1, 1'b1);
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", valid, 1'b0);
    check("midrst_irq", irq, 1'b0);
    check("midrst_state", st, ST_IDLE);
    check("midrst_hs", hs_cnt, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 1;
    hs_cnt = 0;
    push_prog_a();
    cpu_write(CTRL, 32'h1);
    wait_hs(2, 50);
    wait_irq(20, c);
    check("queue_empty4", exp_q.size(), 0);

    // Full memory: slots 0..254, implicit END after slot 254.
    for (int i = 0; i < 255; i++) load(i, mk(i));
    cpu_write(9'h1fe, 32'h1);
    check("rsvd_not_ctrl_irq", irq, 1'b1);
    check("rsvd_not_ctrl_st", st, ST_DONE);
    hs_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      exp_q.push_back(mk(i));
      exp_pc_q.push_back(8'(i));
    end
    cpu_write(CTRL, 32'h1);
    wait_hs(255, 1200);
    wait_irq(20, c);
    check("implicit_end_latency", c - hs_cyc, 2);
    tick(3);
    check("full_hs_total", hs_cnt, 255);
    check("queue_empty5", exp_q.size(), 0);
    check("full_done", st, ST_DONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_instr_loader.md
# cpu_instr_loader

Accelerator-side responder for the CPU peripheral instruction bus. It accepts 32-bit CPU writes, assembles them into 64-bit instructions in an on-chip instruction memory, and decodes the start command at the top control address. Once started, it streams instructions to the compute core over a valid/ready handshake. When the program ends and the core drains, it raises `CPU_instruction_irq`.

## Interface
Parameters:
- `INSTR_NUM_BIT`, default 8: log2 of instruction-memory depth. The bus address is `INSTR_NUM_BIT+1` bits wide.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `CPU_instruction_valid`  in  1  one-cycle write strobe from the CPU.
- `CPU_instruction_addr`  in  INSTR_NUM_BIT+1  write address. Bits `[INSTR_NUM_BIT:1]` are the instruction index; bit 0 selects the half (0 = low `[31:0]`, 1 = high `[63:32]`).
- `CPU_instruction_data`  in  32  write data.
- `CPU_instruction_irq`  out  1  level completion interrupt.
- `core_instr_valid`  out  1  an instruction is offered to the core.
- `core_instr_ready`  in  1  the core accepts the instruction.
- `core_instr_data`  out  64  instruction word.
- `core_instr_pc`  out  INSTR_NUM_BIT  index of the offered instruction.
- `core_busy`  in  1  the core still has work in flight.

## Operation
- **Address map** (all addresses shown for the default `INSTR_NUM_BIT` = 8):
  - All-ones address (0x1ff) is the CTRL register.
  - Slot 255 is reserved: writes to 0x1fe are ignored.
  - Usable program slots are 0..254.
- **Memory**:
  - 2^INSTR_NUM_BIT x 64, synchronous read with 1-cycle latency, not reset.
  - A half write updates only its 32 bits.
- **CTRL write**:
  - `data[0]`=1 means START.
  - Any CTRL write clears the irq.
  - Other data bits are ignored.
- **End of program**: the END instruction has opcode `data[63:56]` == 8'hFF.
  - END is never issued to the core.
  - Issuing slot 254 also ends the program (implicit END).
- **States**:
  - IDLE: memory writes are accepted. CTRL START -> FETCH with pc=0.
  - FETCH: read mem[pc] (one cycle) -> CHECK.
  - CHECK: if the read word is END -> DRAIN. Otherwise drive `core_instr_valid`=1 with the data and pc -> ISSUE.
  - ISSUE: hold valid, data and pc stable until `core_instr_ready`=1.
    - On handshake, if pc == 254 -> DRAIN; else pc+1 -> FETCH.
  - DRAIN: stay for at least one cycle, then wait until `core_busy`=0 is sampled -> DONE.
  - DONE: `CPU_instruction_irq`=1.
    - CTRL write with `data[0]`=0 -> IDLE, irq=0.
    - CTRL write with `data[0]`=1 -> FETCH, pc=0, irq=0.
- **Busy protection**: in FETCH, CHECK, ISSUE and DRAIN, every CPU write (memory and CTRL) is ignored.
- **Memory writes in DONE**: accepted, so the next program can be loaded.
- **Valid strobe**: only cycles with `CPU_instruction_valid`=1 have effect. Address and data are don't-care otherwise.

## Timing
- **Reset values**:
  - State IDLE, pc=0.
  - `core_instr_valid`=0, `core_instr_data`=0, `core_instr_pc`=0.
  - `CPU_instruction_irq`=0.
- **Reset mid-operation**: returns to IDLE immediately and asynchronously. An in-flight offer is dropped and irq is cleared. Memory contents are preserved.
- **Memory write**: a write sampled at edge E is readable by a FETCH at edge E+1 or later.
- **START**: sampled at edge T. FETCH runs in cycle T+1, CHECK in T+2, so `core_instr_valid` is high after edge T+2.
- **Throughput**: one instruction per 3 cycles with ready held high (FETCH, CHECK, ISSUE). A stalled ISSUE adds one cycle per low-ready cycle.
- **Offer stability**: `core_instr_valid` drops the cycle after the handshake, and the offer never changes while valid=1 and ready=0.
- **Completion**: irq rises on the edge that enters DONE and stays high until a CTRL write or reset.
- **Simultaneous events**: a CPU write in the same cycle as a handshake is ignored, because the block is busy.

## Test plan
- Load `0x1111_1111_0000_0000`, `0x2222_2222_0000_0001`, then END (`0xFF00_0000_0000_0000`) at slots 0..2. Write CTRL=1 with ready=1 and busy=0 -> exactly two offers, pc 0 then 1 with matching data, then irq=1 within 3 cycles of the last handshake.
- Same program, with ready toggling 0/1 every cycle and busy=1 for 10 cycles after the last handshake -> data and pc stable during stalls, and irq rises only after busy falls.
- During a run, write mem slot 1 and CTRL=1 -> no memory change and no restart. Reading back by a re-run shows the original data.
- Fill slots 0..254 with non-END words and START -> 255 offers (pc 0..254), then DRAIN, then irq. Slot 255 is never fetched, and a write to 0x1fe is ignored.
- Assert `rst` during the ISSUE of pc 1 -> valid=0, irq=0, state IDLE. A subsequent START replays from pc 0 with the memory intact.
- In DONE, write CTRL=1 -> irq clears next cycle and pc 0 is re-offered 2 cycles later. Write CTRL=0 in DONE -> irq clears and the block goes idle.
